mult_controller: RTL and testbench
==================================

MULT_CONTROLLER -- requirements
Module: mult_controller

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits and number of add/shift iterations; legal range 1..32.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  in  1  request a multiplication; sampled only in IDLE.
REQ-005 SHALL have port abort  in  1  synchronous cancel of an operation in progress.
REQ-006 SHALL have port q0  in  1  LSB of the multiplier (Q) shift register.
REQ-007 SHALL have port ctrl_m  out  2  multiplicand register command (00 hold, 01 shift right, 10 shift left, 11 parallel load).
REQ-008 SHALL have port ctrl_q  out  2  multiplier (Q) register command, same encoding.
REQ-009 SHALL have port ctrl_a  out  2  accumulator (A) register command, same encoding.
REQ-010 SHALL have port a_sel  out  1  A parallel-input mux select: 0 = zero, 1 = adder sum.
REQ-011 SHALL have port c_load  out  1  load adder carry-out into carry flop C.
REQ-012 SHALL have port c_clr  out  1  clear carry flop C.
REQ-013 SHALL have port busy  out  1  high from LOAD through the last SHIFT.
REQ-014 SHALL have port done  out  1  one-cycle pulse; product valid in {A,Q}.
REQ-015 SHALL have port iter  out  $clog2(N+1)  iterations remaining.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, ADD, SHIFT, DONE.
REQ-017 IDLE: all ctrl outputs 00, strobes 0; start=1 -> LOAD next cycle; otherwise stay.
REQ-018 LOAD: ctrl_m=11, ctrl_q=11, ctrl_a=11, a_sel=0, c_clr=1, busy=1, iter loaded with N -> ADD.
REQ-019 ADD: busy=1; if q0=1 then ctrl_a=11, a_sel=1, c_load=1, otherwise all ctrl outputs 00 -> SHIFT.
REQ-020 SHIFT: ctrl_a=01, ctrl_q=01, c_clr=1, busy=1, iter decremented; iter==1 on entry -> DONE, else -> ADD.
REQ-021 DONE: done=1, busy=0, all ctrl outputs 00 -> IDLE unconditionally.
REQ-022 Latency: start accepted -> done asserted exactly 2N+2 cycles later (18 for N=8); fixed and independent of q0.
REQ-023 Minimum start-to-start spacing SHALL be 2N+3 cycles, because one IDLE cycle always follows DONE.
REQ-024 start SHALL be ignored outside IDLE; no request is queued.
REQ-025 ctrl_m SHALL be 00 in every state except LOAD.
REQ-026 abort=1 in LOAD/ADD/SHIFT SHALL force IDLE next cycle with no done pulse; in that cycle all ctrl outputs = 00, and c_load=0 and c_clr=0.
REQ-027 abort SHALL have no effect in IDLE or DONE; abort and start both high in IDLE -> start wins.
REQ-028 ctrl outputs, a_sel, c_load, c_clr, busy and done SHALL be decoded combinationally from state and q0 (Moore except ADD's q0 dependence).
REQ-029 ctrl_* SHALL never take value 10.
REQ-030 N=1 SHALL yield sequence LOAD, ADD, SHIFT, DONE (latency 4).

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE and set iter to 0, overriding start and abort.
REQ-032 During and after reset, all ctrl outputs SHALL be 00, and a_sel, c_load, c_clr, busy and done SHALL be 0.
REQ-033 Reset mid-operation SHALL discard the operation with no done pulse; the datapath registers hold their values.

Structure
REQ-034 Package mult_pkg SHALL hold the state enum and the shift-register command constants HOLD/SHIFT_RIGHT/SHIFT_LEFT/PARALLEL_LOAD.
REQ-035 The iteration counter (load N, decrement, last flag) SHALL be sub-module mult_iter_counter; the FSM and output decode stay in mult_controller.

Verification
REQ-036 N=8, start pulse, bench Q model = 0xA5 -> exactly 4 ADD cycles with ctrl_a=11, and done at cycle 18 after start.
REQ-037 Controller wired to two N=8 shift registers, an adder and a C flop; operands 13 x 11 -> {A,Q}=0x008F (143) at done; 255 x 255 -> 0xFE01.
REQ-038 start held high continuously -> done pulses every 19 cycles; busy low only in the DONE and IDLE cycles.
REQ-039 abort in the 5th cycle after start -> next cycle IDLE, all ctrl outputs 00, no done; a following start runs normally.
REQ-040 rst asserted at cycle 7 of an operation with start high -> IDLE, all outputs 0 and iter=0; start after release -> done 18 cycles later.
REQ-041 N=1, q0=1 -> LOAD, ADD(ctrl_a=11), SHIFT, DONE; done 4 cycles after start.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier controller: FSM states and
// the 2-bit command encoding understood by the datapath shift registers.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    SHIFT,
    DONE
  } state_e;

  localparam logic [1:0] HOLD          = 2'b00;
  localparam logic [1:0] SHIFT_RIGHT   = 2'b01;
  localparam logic [1:0] SHIFT_LEFT    = 2'b10;
  localparam logic [1:0] PARALLEL_LOAD = 2'b11;

endpackage

// File: rtl/mult_iter_counter.sv
// Down-counter of remaining add/shift iterations; loads N at the start of an
// operation and flags the final iteration.
module mult_iter_counter #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic                   dec_i,
  output logic [$clog2(N+1)-1:0] iter_o,
  output logic                   last_o
);

  localparam int W = $clog2(N + 1);

  logic [W-1:0] iter_q;
  logic [W-1:0] iter_d;

  // NOTE: iter_d takes its hold value before any condition so no path leaves it unassigned (no latch).
  always_comb begin
    iter_d = iter_q;
    if (load_i) begin
      iter_d = W'(N);
    end else if (dec_i) begin
      iter_d = iter_q - W'(1);
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  assign iter_o = iter_q;
  assign last_o = (iter_q == W'(1));

endmodule

// File: rtl/mult_controller.sv
// Sequencer for an N-bit shift-and-add multiplier: drives the M, Q and A
// register commands, the A input mux and the carry flop, one add/shift pair per bit.
module mult_controller #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   q0,
  output logic [1:0]             ctrl_m,
  output logic [1:0]             ctrl_q,
  output logic [1:0]             ctrl_a,
  output logic                   a_sel,
  output logic                   c_load,
  output logic                   c_clr,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(N+1)-1:0] iter
);

  import mult_pkg::*;

  state_e state_q;
  state_e state_d;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_last;

  mult_iter_counter #(.N(N)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .iter_o (iter),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_m   = HOLD;
    ctrl_q   = HOLD;
    ctrl_a   = HOLD;
    a_sel    = 1'b0;
    c_load   = 1'b0;
    c_clr    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        ctrl_m   = PARALLEL_LOAD;
        ctrl_q   = PARALLEL_LOAD;
        ctrl_a   = PARALLEL_LOAD;
        c_clr    = 1'b1;
        busy     = 1'b1;
        cnt_load = 1'b1;
        state_d  = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (q0) begin
          ctrl_a = PARALLEL_LOAD;
          a_sel  = 1'b1;
          c_load = 1'b1;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        ctrl_a  = SHIFT_RIGHT;
        ctrl_q  = SHIFT_RIGHT;
        c_clr   = 1'b1;
        busy    = 1'b1;
        cnt_dec = 1'b1;
        state_d = cnt_last ? DONE : ADD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Cancelling freezes the datapath in the same cycle the FSM falls back to IDLE.
    if (abort && busy) begin
      ctrl_m   = HOLD;
      ctrl_q   = HOLD;
      ctrl_a   = HOLD;
      a_sel    = 1'b0;
      c_load   = 1'b0;
      c_clr    = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      state_d  = IDLE;
    end

    // Quiet outputs while reset is held so the datapath keeps its contents.
    if (rst) begin
      ctrl_m   = HOLD;
      ctrl_q   = HOLD;
      ctrl_a   = HOLD;
      a_sel    = 1'b0;
      c_load   = 1'b0;
      c_clr    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller: an N=8 instance driving a shift-and-add datapath
// and an N=1 instance, both compared every cycle against a step-count model.
module tb_mult_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, q0_1;
  logic [7:0] op_m, op_q;

  logic [1:0] ctrl_m8, ctrl_q8, ctrl_a8;
  logic       a_sel8, c_load8, c_clr8, busy8, done8;
  logic [3:0] iter8;
  logic [1:0] ctrl_m1, ctrl_q1, ctrl_a1;
  logic       a_sel1, c_load1, c_clr1, busy1, done1;
  logic [0:0] iter1;

  logic [7:0] m_q = '0;
  logic [7:0] q_q = '0;
  logic [7:0] a_q = '0;
  logic       c_q = 1'b0;
  logic [8:0] sum;

  mult_controller #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .q0(q_q[0]),
    .ctrl_m(ctrl_m8), .ctrl_q(ctrl_q8), .ctrl_a(ctrl_a8), .a_sel(a_sel8),
    .c_load(c_load8), .c_clr(c_clr8), .busy(busy8), .done(done8), .iter(iter8)
  );

  mult_controller #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .q0(q0_1),
    .ctrl_m(ctrl_m1), .ctrl_q(ctrl_q1), .ctrl_a(ctrl_a1), .a_sel(a_sel1),
    .c_load(c_load1), .c_clr(c_clr1), .busy(busy1), .done(done1), .iter(iter1)
  );

  // Datapath: M, Q, A shift registers, an adder and the carry flop C.
  assign sum = {1'b0, a_q} + {1'b0, m_q};
  always @(posedge clk) begin
    if (ctrl_m8 == 2'b11) m_q <= op_m;
    case (ctrl_a8)
      2'b11:   a_q <= a_sel8 ? sum[7:0] : 8'd0;
      2'b01:   a_q <= {c_q, a_q[7:1]};
      2'b10:   a_q <= {a_q[6:0], 1'b0};
      default: ;
    endcase
    case (ctrl_q8)
      2'b11:   q_q <= op_q;
      2'b01:   q_q <= {a_q[0], q_q[7:1]};
      2'b10:   q_q <= {q_q[6:0], 1'b0};
      default: ;
    endcase
    if (c_clr8)       c_q <= 1'b0;
    else if (c_load8) c_q <= sum[8];
  end

  // Model: an operation is a numbered step k = 1 .. 2n+2 after start acceptance.
  // k=1 load, even k add, odd k>=3 shift, k=2n+2 done.
  typedef struct packed {
    logic [1:0] m, q, a;
    logic a_sel, c_load, c_clr, busy, done, a_sel_care;
  } out_t;

  typedef struct packed {
    bit active;
    int k;
    bit iter_known;
    int iter_idle;
  } mdl_t;

  function automatic out_t exp_out(input int n, input mdl_t s, input logic q0,
                                   input logic ab, input logic r);
    out_t o;
    o = '0;
    o.a_sel_care = 1'b1;
    if (r || !s.active) return o;
    if (s.k == 2 * n + 2) begin
      o.done = 1'b1;
      return o;
    end
    o.busy = 1'b1;
    if (ab) begin
      o.a_sel_care = 1'b0;
      return o;
    end
    if (s.k == 1) begin
      o.m = 2'b11; o.q = 2'b11; o.a = 2'b11; o.c_clr = 1'b1;
    end else if (s.k % 2 == 0) begin
      if (q0) begin
        o.a = 2'b11; o.a_sel = 1'b1; o.c_load = 1'b1;
      end else begin
        o.a_sel_care = 1'b0;
      end
    end else begin
      o.a = 2'b01; o.q = 2'b01; o.c_clr = 1'b1;
    end
    return o;
  endfunction

  function automatic int exp_iter(input int n, input mdl_t s);
    if (s.active && s.k >= 2) return n - (s.k - 2) / 2;
    if (s.iter_known) return s.iter_idle;
    return -1;
  endfunction

  function automatic mdl_t step(input int n, input mdl_t s, input logic st,
                                input logic ab, input logic r);
    mdl_t ns;
    ns = s;
    if (r) begin
      ns.active = 1'b0; ns.iter_known = 1'b1; ns.iter_idle = 0;
    end else if (!s.active) begin
      if (st) begin
        ns.active = 1'b1; ns.k = 1;
      end
    end else if (s.k == 2 * n + 2) begin
      ns.active = 1'b0; ns.iter_known = 1'b1; ns.iter_idle = 0;
    end else if (ab) begin
      ns.active = 1'b0; ns.iter_known = 1'b0;
    end else begin
      ns.k = s.k + 1;
    end
    return ns;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int n, input mdl_t s, input logic q0,
                            input logic [1:0] m, input logic [1:0] q, input logic [1:0] a,
                            input logic as, input logic cl, input logic cc,
                            input logic b, input logic d, input logic [31:0] it);
    out_t e;
    int   ei;
    e  = exp_out(n, s, q0, abort, rst);
    ei = exp_iter(n, s);
    check({tag, ".ctrl_m"}, 32'(m),  32'(e.m));
    check({tag, ".ctrl_q"}, 32'(q),  32'(e.q));
    check({tag, ".ctrl_a"}, 32'(a),  32'(e.a));
    check({tag, ".c_load"}, 32'(cl), 32'(e.c_load));
    check({tag, ".c_clr"},  32'(cc), 32'(e.c_clr));
    check({tag, ".busy"},   32'(b),  32'(e.busy));
    check({tag, ".done"},   32'(d),  32'(e.done));
    if (e.a_sel_care) check({tag, ".a_sel"}, 32'(as), 32'(e.a_sel));
    if (ei >= 0)      check({tag, ".iter"},  it, 32'(ei));
  endtask

  mdl_t        s8 = '0;
  mdl_t        s1 = '0;
  bit          model_valid = 1'b0;
  logic [15:0] exp_prod = '0;

  always @(negedge clk) begin
    if (model_valid || rst) begin
      check_outs("n8", 8, s8, q_q[0], ctrl_m8, ctrl_q8, ctrl_a8, a_sel8, c_load8,
                 c_clr8, busy8, done8, 32'(iter8));
      check_outs("n1", 1, s1, q0_1, ctrl_m1, ctrl_q1, ctrl_a1, a_sel1, c_load1,
                 c_clr1, busy1, done1, 32'(iter1));
      if (s8.active && s8.k == 18) check("product", 32'({a_q, q_q}), 32'(exp_prod));
    end
    if (!rst && s8.active && s8.k == 1 && !abort) exp_prod = op_m * op_q;
    s8 = step(8, s8, start, abort, rst);
    s1 = step(1, s1, start, abort, rst);
    if (rst) model_valid = 1'b1;
  end

  // Called at posedge+1 with the N=8 instance idle; returns latency, add count, product.
  task automatic run_op(input logic [7:0] m, input logic [7:0] q, output int lat,
                        output int adds, output logic [15:0] prod);
    op_m = m; op_q = q; start = 1'b1;
    lat = 0; adds = 0; prod = '0;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (ctrl_a8 == 2'b11 && a_sel8) adds++;
      if (done8) begin
        lat  = c;
        prod = {a_q, q_q};
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          lat, adds, dones;
    logic [15:0] prod;
    int          t[$];

    rst = 1'b1; start = 1'b0; abort = 1'b0; q0_1 = 1'b0; op_m = '0; op_q = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy8), 0);
    check("reset_iter", 32'(iter8), 0);
    @(posedge clk); #1;

    run_op(8'h3C, 8'hA5, lat, adds, prod);
    check("a5_adds", adds, 4);
    check("a5_latency", lat, 18);
    check("a5_prod", 32'(prod), 32'h26AC);
    @(posedge clk); #1;
    run_op(8'd13, 8'd11, lat, adds, prod);
    check("13x11_prod", 32'(prod), 32'h008F);
    check("13x11_adds", adds, 3);
    @(posedge clk); #1;
    run_op(8'd255, 8'd255, lat, adds, prod);
    check("255x255_prod", 32'(prod), 32'hFE01);
    check("255x255_latency", lat, 18);

    // start held high: done every 2N+3 cycles
    @(posedge clk); #1;
    op_m = 8'd5; op_q = 8'd6; start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done8) t.push_back(c);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("held_done_count", t.size(), 3);
    if (t.size() > 0) check("held_first_done", t[0], 18);
    for (int i = 1; i < t.size(); i++) check("held_gap", t[i] - t[i-1], 19);
    repeat (25) @(posedge clk);
    #1;

    // abort in the 5th cycle after start
    op_m = 8'd9; op_q = 8'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort_cycle_ctrl_a", 32'(ctrl_a8), 0);
    check("abort_cycle_c_clr", 32'(c_clr8), 0);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_next_busy", 32'(busy8), 0);
    check("abort_next_ctrl", 32'({ctrl_m8, ctrl_q8, ctrl_a8}), 0);
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done8) dones++;
    end
    check("abort_no_done", dones, 0);
    @(posedge clk); #1;
    run_op(8'd7, 8'd9, lat, adds, prod);
    check("after_abort_latency", lat, 18);
    check("after_abort_prod", 32'(prod), 63);

    // reset at cycle 7 of an operation with start high
    @(posedge clk); #1;
    op_m = 8'd1; op_q = 8'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy8), 0);
    check("rst_iter", 32'(iter8), 0);
    check("rst_ctrl", 32'({ctrl_m8, ctrl_q8, ctrl_a8, done8}), 0);
    @(posedge clk); #1;
    run_op(8'd200, 8'd3, lat, adds, prod);
    check("after_rst_latency", lat, 18);
    check("after_rst_prod", 32'(prod), 600);

    // N=1 instance sequence with q0=1
    @(posedge clk); #1;
    q0_1 = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); check("n1_load_ctrl_m", 32'(ctrl_m1), 3);
    @(posedge clk); #1;
    @(negedge clk); check("n1_add", 32'({ctrl_a1, a_sel1}), 3'b111);
    @(posedge clk); #1;
    @(negedge clk); check("n1_shift", 32'(ctrl_a1), 1);
    @(posedge clk); #1;
    @(negedge clk); check("n1_done", 32'(done1), 1);
    repeat (25) @(posedge clk);
    #1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 19) == 0);
      q0_1  = 1'($urandom);
      op_m  = 8'($urandom);
      op_q  = 8'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (25) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
